gpio_input_capture: RTL and testbench

GPIO_INPUT_CAPTURE -- requirements
Module: gpio_input_capture

---
 rtl/gpio_input_capture.sv | 110 +++++++++++
 tb/tb_gpio_input_capture.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_capture.sv
// GPIO input capture: two-flop synchroniser, per-word debounce FSM, and
// pending/overrun bookkeeping for bus reads of the committed value.
module gpio_input_capture #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SIZE-1:0]  pins,
  input  logic [CNT_W-1:0] dbnc_len,
  input  logic             rd_ack,
  output logic [SIZE-1:0]  data,
  output logic             NewData,
  output logic             pending,
  output logic             overrun,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  logic [SIZE-1:0]  sync_d;
  logic [SIZE-1:0]  sync_q;
  logic [SIZE-1:0]  cand;
  logic [CNT_W-1:0] cnt;
  logic             commit;

  assign fsm_state = state;

  // The edge on which data is loaded; shared with the pending/overrun flags.
  assign commit = en && (state == SETTLE) && (sync_q == cand) && (cnt == dbnc_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_d <= '0;
      sync_q <= '0;
    end else begin
      sync_d <= pins;
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cand    <= '0;
      cnt     <= '0;
      data    <= '0;
      NewData <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      NewData <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          NewData <= 1'b0;
          if (sync_q != data) begin
            cand  <= sync_q;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync_q != cand) begin
            // Bounce: restart the stability window on the new value.
            cand <= sync_q;
            cnt  <= '0;
            if (sync_q == data) state <= IDLE;
          end else if (cnt == dbnc_len) begin
            data    <= cand;
            NewData <= 1'b1;
            state   <= COMMIT;
          end else begin
            // Equality-only compare: a lowered dbnc_len makes cnt wrap.
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          NewData <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          NewData <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // pending marks an unread commit; rd_ack retires it unless a commit lands
  // on the same edge, in which case the fresh value stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (commit)      pending <= 1'b1;
      else if (rd_ack) pending <= 1'b0;

      if (commit && pending && !rd_ack) overrun <= 1'b1;
      else if (rd_ack && !commit)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture: latency, debounce, flags, gating, reset.
module tb_gpio_input_capture;

  localparam int SIZE  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [SIZE-1:0]  pins;
  logic [CNT_W-1:0] dbnc_len;
  logic             rd_ack;
  logic [SIZE-1:0]  data;
  logic             NewData;
  logic             pending;
  logic             overrun;
  logic [1:0]       fsm_state;

  int checks;
  int failures;
  int pulses;

  gpio_input_capture #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pins      (pins),
    .dbnc_len  (dbnc_len),
    .rd_ack    (rd_ack),
    .data      (data),
    .NewData   (NewData),
    .pending   (pending),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int p);
    p = 0;
    repeat (n) begin
      tick();
      if (NewData) p++;
    end
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pins = '0; dbnc_len = '0; rd_ack = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
    checks++; if (NewData !== 1'b0) begin failures++; $display("FAIL reset_newdata got=%b exp=0", NewData); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_basic_commit();
    dbnc_len = 4'd0;
    tick();
    pins = 32'h0000_00A5;
    run(3, pulses);
    checks++; if (pulses !== 0 || data !== 32'h0) begin failures++; $display("FAIL basic_early pulses=%0d data=%h exp 0/0", pulses, data); end
    tick();
    checks++; if (data !== 32'h0000_00A5) begin failures++; $display("FAIL basic_data got=%h exp=000000a5", data); end
    checks++; if (NewData !== 1'b1) begin failures++; $display("FAIL basic_newdata got=%b exp=1", NewData); end
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL basic_pending got=%b exp=1", pending); end
    tick();
    checks++; if (NewData !== 1'b0 || fsm_state !== 2'd0) begin failures++; $display("FAIL basic_pulse_end newdata=%b state=%0d exp 0/0", NewData, fsm_state); end
    ack_pulse();
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL basic_ack pending=%b exp=0", pending); end
  endtask

  task automatic test_glitch();
    rst = 1'b0; pins = '0; tick(); tick(); rst = 1'b1;
    dbnc_len = 4'd3;
    pins = 32'h1;
    tick(); tick();
    pins = 32'h0;
    run(12, pulses);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", pulses); end
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL glitch_data got=%h exp=0", data); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL glitch_state got=%0d exp=0", fsm_state); end
  endtask

  task automatic test_bounce();
    int total;
    dbnc_len = 4'd3;
    total = 0;
    for (int i = 0; i < 3; i++) begin
      pins = (i % 2 == 0) ? 32'h1 : 32'h3;
      run(2, pulses);
      total += pulses;
    end
    pins = 32'h3;
    run(6, pulses);
    total += pulses;
    checks++; if (total !== 0) begin failures++; $display("FAIL bounce_early pulses=%0d exp=0", total); end
    tick();
    checks++; if (NewData !== 1'b1 || data !== 32'h3) begin failures++; $display("FAIL bounce_commit newdata=%b data=%h exp 1/3", NewData, data); end
    run(8, pulses);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL bounce_single extra_pulses=%0d exp=0", pulses); end
  endtask

  task automatic test_overrun();
    dbnc_len = 4'd0;
    ack_pulse();
    ack_pulse();
    checks++; if (pending !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL ack_idle pending=%b overrun=%b exp 0/0", pending, overrun); end
    pins = 32'h5;
    run(5, pulses);
    checks++; if (pending !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_first pending=%b overrun=%b exp 1/0", pending, overrun); end
    pins = 32'h6;
    run(5, pulses);
    checks++; if (pending !== 1'b1 || overrun !== 1'b1) begin failures++; $display("FAIL ovr_second pending=%b overrun=%b exp 1/1", pending, overrun); end
    ack_pulse();
    checks++; if (pending !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack pending=%b overrun=%b exp 0/0", pending, overrun); end
    pins = 32'h9;
    run(5, pulses);
    pins = 32'hC;
    tick(); tick(); tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    checks++; if (NewData !== 1'b1 || data !== 32'hC) begin failures++; $display("FAIL coincide_commit newdata=%b data=%h exp 1/c", NewData, data); end
    checks++; if (pending !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL coincide_flags pending=%b overrun=%b exp 1/0", pending, overrun); end
    tick();
  endtask

  task automatic test_enable();
    dbnc_len = 4'd2;
    en = 1'b0;
    pins = 32'hFFFF_FFFF;
    run(20, pulses);
    checks++; if (pulses !== 0 || data !== 32'hC) begin failures++; $display("FAIL en_off pulses=%0d data=%h exp 0/c", pulses, data); end
    en = 1'b1;
    run(3, pulses);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL en_early pulses=%0d exp=0", pulses); end
    tick();
    checks++; if (NewData !== 1'b1 || data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL en_commit newdata=%b data=%h exp 1/ffffffff", NewData, data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL en_overrun got=%b exp=1", overrun); end
    tick();
  endtask

  task automatic test_reset_mid();
    dbnc_len = 4'd3;
    pins = 32'h5;
    run(7, pulses);
    checks++; if (data !== 32'h5 || pulses !== 1) begin failures++; $display("FAIL mid_setup data=%h pulses=%0d exp 5/1", data, pulses); end
    tick();
    pins = 32'h7;
    tick(); tick(); tick(); tick();
    checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL mid_settle state=%0d exp=1", fsm_state); end
    #2 rst = 1'b0;
    #1;
    checks++; if (data !== 32'h0 || NewData !== 1'b0) begin failures++; $display("FAIL mid_rst_data data=%h newdata=%b exp 0/0", data, NewData); end
    checks++; if (pending !== 1'b0 || overrun !== 1'b0 || fsm_state !== 2'd0) begin failures++; $display("FAIL mid_rst_flags pending=%b overrun=%b state=%0d exp 0/0/0", pending, overrun, fsm_state); end
    pins = 32'h5;
    tick(); tick();
    rst = 1'b1;
    run(6, pulses);
    checks++; if (pulses !== 0 || data !== 32'h0) begin failures++; $display("FAIL mid_early pulses=%0d data=%h exp 0/0", pulses, data); end
    tick();
    checks++; if (NewData !== 1'b1 || data !== 32'h5) begin failures++; $display("FAIL mid_recommit newdata=%b data=%h exp 1/5", NewData, data); end
    tick();
  endtask

  task automatic test_dbnc_wrap();
    dbnc_len = 4'd5;
    pins = 32'hF0;
    run(6, pulses);
    dbnc_len = 4'd1;
    run(14, pulses);
    checks++; if (pulses !== 0 || data !== 32'h5) begin failures++; $display("FAIL wrap_early pulses=%0d data=%h exp 0/5", pulses, data); end
    tick();
    checks++; if (NewData !== 1'b1 || data !== 32'hF0) begin failures++; $display("FAIL wrap_commit newdata=%b data=%h exp 1/f0", NewData, data); end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_commit();
    test_glitch();
    test_bounce();
    test_overrun();
    test_enable();
    test_reset_mid();
    test_dbnc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
